// File: rtl/ysyx_23060221_pipe_pkg.sv
// Shared pipeline tag types and the destination-match helper for the hazard controller.
package ysyx_23060221_pipe_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 32;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             wen;
    logic             load;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             rs1_used;
    logic             rs2_used;
  } tag_payload_t;

  typedef struct packed {
    logic         v;
    tag_payload_t p;
  } stage_tag_t;

  // A slot supplies register r only if it will write it; x0 is hardwired and never forwarded.
  function automatic logic tag_match(input stage_tag_t s, input logic [REG_W-1:0] r);
    return s.v & s.p.wen & (s.p.rd == r) & (r != '0);
  endfunction

endpackage

// File: rtl/ysyx_23060221_stage_tag.sv
// One in-flight instruction tag slot: kill/reset > load > clear > hold on the valid bit.
module ysyx_23060221_stage_tag
  import ysyx_23060221_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_clear,
  input  logic       i_kill,
  input  stage_tag_t i_d,
  output stage_tag_t o_q
);

  logic         r_v;
  tag_payload_t r_p;

  always_ff @(posedge clk) begin
    if (rst || i_kill) begin
      r_v <= 1'b0;
    end else if (i_load) begin
      r_v <= i_d.v;
    end else if (i_clear) begin
      r_v <= 1'b0;
    end
  end

  // Payload is only meaningful while r_v is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_p <= i_d.p;
    end
  end

  always_comb begin
    o_q   = '0;
    o_q.v = r_v;
    o_q.p = r_p;
  end

endmodule

// File: rtl/ysyx_23060221_hazard_ctrl.sv
// Operand forwarding and load-use hold for the EXU, tracking EX/LS/WB destination tags.
// Define HAZARD_PERF_EN to add the stall-cycle and forward-count perf counters.
module ysyx_23060221_hazard_ctrl
  import ysyx_23060221_pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             id_ex_fire,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wen,
  input  logic             id_is_load,
  input  logic             ex_ls_fire,
  input  logic             ls_wb_fire,
  input  logic             wb_retire,
  input  logic             ls_data_ok,
  input  logic             flush,
  output logic             ca1,
  output logic             ca2,
  output logic             cb1,
  output logic             cb2,
  output logic             ex_hold
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cyc,
  output logic [CNT_W-1:0] perf_fwd_cnt
`endif
);

  stage_tag_t w_ex_d;
  stage_tag_t w_ex;
  stage_tag_t w_ls;
  stage_tag_t w_wb;
  logic       w_src1_live;
  logic       w_src2_live;
  logic       w_unused;

  always_comb begin
    w_ex_d            = '0;
    w_ex_d.v          = 1'b1;
    w_ex_d.p.rd       = id_rd;
    w_ex_d.p.wen      = id_wen;
    w_ex_d.p.load     = id_is_load;
    w_ex_d.p.rs1      = id_rs1;
    w_ex_d.p.rs2      = id_rs2;
    w_ex_d.p.rs1_used = id_rs1_used;
    w_ex_d.p.rs2_used = id_rs2_used;
  end

  // Redirect kills only the EX slot; an instruction entering on the same edge is dropped.
  ysyx_23060221_stage_tag u_ex (
    .clk     (clk),
    .rst     (rst),
    .i_load  (id_ex_fire),
    .i_clear (ex_ls_fire),
    .i_kill  (flush),
    .i_d     (w_ex_d),
    .o_q     (w_ex)
  );

  ysyx_23060221_stage_tag u_ls (
    .clk     (clk),
    .rst     (rst),
    .i_load  (ex_ls_fire),
    .i_clear (ls_wb_fire),
    .i_kill  (1'b0),
    .i_d     (w_ex),
    .o_q     (w_ls)
  );

  ysyx_23060221_stage_tag u_wb (
    .clk     (clk),
    .rst     (rst),
    .i_load  (ls_wb_fire),
    .i_clear (wb_retire),
    .i_kill  (1'b0),
    .i_d     (w_ls),
    .o_q     (w_wb)
  );

  // WB is the last slot; its source fields are never consulted.
  assign w_unused = ^{w_wb.p.load, w_wb.p.rs1, w_wb.p.rs2, w_wb.p.rs1_used, w_wb.p.rs2_used};

  assign w_src1_live = w_ex.v & w_ex.p.rs1_used;
  assign w_src2_live = w_ex.v & w_ex.p.rs2_used;

  // LS holds the younger producer, so it wins over WB.
  always_comb begin
    ca1     = 1'b0;
    ca2     = 1'b0;
    cb1     = 1'b0;
    cb2     = 1'b0;
    ex_hold = 1'b0;
    ca1     = w_src1_live & tag_match(w_ls, w_ex.p.rs1);
    ca2     = w_src1_live & ~ca1 & tag_match(w_wb, w_ex.p.rs1);
    cb1     = w_src2_live & tag_match(w_ls, w_ex.p.rs2);
    cb2     = w_src2_live & ~cb1 & tag_match(w_wb, w_ex.p.rs2);
    ex_hold = w_ex.v & ((ca1 | cb1) & w_ls.p.load) & ~ls_data_ok;
  end

  a_hold_blocks_fire: assert property (@(posedge clk) disable iff (rst) !(ex_hold && ex_ls_fire));

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cyc;
  logic [CNT_W-1:0] r_fwd_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cyc <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (ex_hold) begin
        r_stall_cyc <= r_stall_cyc + CNT_W'(1);
      end
      if (ex_ls_fire && w_ex.v && (ca1 || ca2 || cb1 || cb2)) begin
        r_fwd_cnt <= r_fwd_cnt + CNT_W'(1);
      end
    end
  end

  assign perf_stall_cyc = r_stall_cyc;
  assign perf_fwd_cnt   = r_fwd_cnt;
`endif

endmodule

// File: tb/tb_ysyx_23060221_hazard_ctrl.sv
// Directed bench for the hazard controller; checks {ca1,ca2,cb1,cb2,ex_hold} against hand values.
module tb_ysyx_23060221_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       id_ex_fire;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] id_rd;
  logic       id_wen;
  logic       id_is_load;
  logic       ex_ls_fire;
  logic       ls_wb_fire;
  logic       wb_retire;
  logic       ls_data_ok;
  logic       flush;
  logic       ca1;
  logic       ca2;
  logic       cb1;
  logic       cb2;
  logic       ex_hold;

  int checks = 0;
  int errors = 0;

  ysyx_23060221_hazard_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .id_ex_fire  (id_ex_fire),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_wen      (id_wen),
    .id_is_load  (id_is_load),
    .ex_ls_fire  (ex_ls_fire),
    .ls_wb_fire  (ls_wb_fire),
    .wb_retire   (wb_retire),
    .ls_data_ok  (ls_data_ok),
    .flush       (flush),
    .ca1         (ca1),
    .ca2         (ca2),
    .cb1         (cb1),
    .cb2         (cb2),
    .ex_hold     (ex_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {ca1, ca2, cb1, cb2, ex_hold};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed={ca1,ca2,cb1,cb2,hold}=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_ex_fire  = 1'b0;
    ex_ls_fire  = 1'b0;
    ls_wb_fire  = 1'b0;
    wb_retire   = 1'b0;
    flush       = 1'b0;
    id_rs1      = '0;
    id_rs2      = '0;
    id_rs1_used = 1'b0;
    id_rs2_used = 1'b0;
    id_rd       = '0;
    id_wen      = 1'b0;
    id_is_load  = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic wen, input logic ld,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2);
    id_ex_fire  = 1'b1;
    id_rd       = rd;
    id_wen      = wen;
    id_is_load  = ld;
    id_rs1      = rs1;
    id_rs1_used = u1;
    id_rs2      = rs2;
    id_rs2_used = u2;
  endtask

  task automatic all_fires();
    ex_ls_fire = 1'b1;
    ls_wb_fire = 1'b1;
    wb_retire  = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      clr();
      all_fires();
      tick();
    end
    clr();
  endtask

  initial begin
    clr();
    ls_data_ok = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset", 5'b00000);

    // ALU-to-ALU back-to-back: src1 from LS.
    clr(); issue(5'd5, 1, 0, 5'd1, 1, 5'd2, 1); tick();
    clr(); issue(5'd6, 1, 0, 5'd5, 1, 5'd1, 1); ex_ls_fire = 1; tick();
    check("t1_fwd_ls_src1", 5'b10000);

    // Producer two ahead sits in WB: src2 from WB.
    clr(); issue(5'd7, 1, 0, 5'd3, 1, 5'd5, 1); ex_ls_fire = 1; ls_wb_fire = 1; tick();
    check("t2_fwd_wb_src2", 5'b00010);
    clr(); issue(5'd5, 1, 0, 5'd0, 0, 5'd0, 0); all_fires(); tick();
    clr(); issue(5'd5, 1, 0, 5'd0, 0, 5'd0, 0); all_fires(); tick();
    clr(); issue(5'd9, 1, 0, 5'd9, 1, 5'd5, 1); all_fires(); tick();
    check("t2_ls_over_wb", 5'b00100);
    drain();
    check("drained", 5'b00000);

    // Load-use: hold three cycles, release same cycle data arrives.
    clr(); issue(5'd7, 1, 1, 5'd2, 1, 5'd0, 0); tick();
    clr(); issue(5'd8, 1, 0, 5'd7, 1, 5'd7, 1); all_fires(); tick();
    clr();
    check("t3_hold_c0", 5'b10101);
    tick();
    check("t3_hold_c1", 5'b10101);
    tick();
    check("t3_hold_c2", 5'b10101);
    ls_data_ok = 1'b1;
    #1;
    check("t3_release", 5'b10100);
    ex_ls_fire = 1; ls_wb_fire = 1; tick();
    ls_data_ok = 1'b0;
    clr();
    check("t3_after", 5'b00000);
    drain();

    // x0 never forwarded; unused operand never selects.
    clr(); issue(5'd0, 1, 0, 5'd0, 0, 5'd0, 0); all_fires(); tick();
    clr(); issue(5'd13, 1, 0, 5'd0, 1, 5'd0, 1); all_fires(); tick();
    check("t4_x0", 5'b00000);
    clr(); issue(5'd14, 1, 0, 5'd13, 0, 5'd13, 1); all_fires(); tick();
    check("t4_unused_rs1", 5'b00100);
    drain();

    // Flush beats a same-cycle ID->EX fire; LS slot stays put.
    clr(); issue(5'd10, 1, 0, 5'd0, 0, 5'd0, 0); tick();
    clr(); issue(5'd11, 1, 0, 5'd10, 1, 5'd0, 0); ex_ls_fire = 1; tick();
    check("t5_pre", 5'b10000);
    clr(); issue(5'd12, 1, 0, 5'd10, 1, 5'd10, 1); flush = 1; tick();
    clr();
    check("t5_flush", 5'b00000);
    issue(5'd15, 1, 0, 5'd10, 1, 5'd0, 0); tick();
    clr();
    check("t5_ls_kept", 5'b10000);
    drain();

    // Reset with all three slots valid and a hold pending.
    clr(); issue(5'd20, 1, 0, 5'd0, 0, 5'd0, 0); tick();
    clr(); issue(5'd11, 1, 1, 5'd0, 0, 5'd0, 0); ex_ls_fire = 1; tick();
    clr(); issue(5'd21, 1, 0, 5'd11, 1, 5'd20, 1); ex_ls_fire = 1; ls_wb_fire = 1; tick();
    clr();
    check("t6_pre", 5'b10011);
    issue(5'd22, 1, 0, 5'd11, 1, 5'd20, 1); ls_wb_fire = 1; wb_retire = 1;
    rst = 1'b1;
    tick();
    check("t6_reset", 5'b00000);
    rst = 1'b0;
    clr();
    tick();
    check("t6_idle", 5'b00000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
